counter: RTL and testbench



---
 rtl/counter.sv | 59 +++++
 tb/tb_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Free-running modulo up-counter with asynchronous active-low reset.
// Optional `COUNTER_RST_SYNC_EN adds a 2-flop reset-release synchronizer.
module counter #(
  parameter int unsigned      WIDTH       = 4,
  parameter longint unsigned  MODULUS     = 64'd1 << WIDTH,
  parameter int unsigned      STEP        = 1,
  parameter int unsigned      RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH:0]   ModW   = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   StepW  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   sum;
  logic             run;

  // One extra bit so count + STEP can never overflow silently before the wrap compare.
  always_comb begin
    sum = {1'b0, count_q} + StepW;
    if (sum >= ModW) begin
      count_d = WIDTH'(sum - ModW);
    end else begin
      count_d = sum[WIDTH-1:0];
    end
  end

`ifdef COUNTER_RST_SYNC_EN
  logic [1:0] rst_sync_q;

  // Assertion is asynchronous; release ripples through two flops before counting starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];
`else
  assign run = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RstVal;
    end else if (run) begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: default build and a MODULUS=10/STEP=3 instance,
// table vectors, hand-written reset corner cases and randomized reset activity.
module tb_counter;

`ifdef COUNTER_RST_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt_def;
  logic [3:0] cnt_m10;

  int checks = 0;
  int errors = 0;
  int rel_edges = 0;

  always #5 clk = ~clk;

  counter dut_def (
    .clk   (clk),
    .reset (reset),
    .count (cnt_def)
  );

  counter #(
    .WIDTH       (4),
    .MODULUS     (10),
    .STEP        (3),
    .RESET_VALUE (0)
  ) dut_m10 (
    .clk   (clk),
    .reset (reset),
    .count (cnt_m10)
  );

  // Expected value: number of counting edges since release times STEP, modulo MODULUS.
  function automatic int exp_val(input int modulus, input int step);
    int k;
    k = (rel_edges > SyncLat) ? rel_edges - SyncLat : 0;
    return (k * step) % modulus;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) rel_edges++;
    #1;
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (!v) rel_edges = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_def"}, int'(cnt_def), exp_val(16, 1));
    check({tag, "_m10"}, int'(cnt_m10), exp_val(10, 3));
    check({tag, "_m10_range"}, int'(cnt_m10 < 4'd10), 1);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] exp_def;
    logic [3:0] exp_m10;
  } vec_t;

  vec_t vecs[12];

`ifdef COUNTER_RST_SYNC_EN
  localparam logic [3:0] Exp100 = 4'd2;
`else
  localparam logic [3:0] Exp100 = 4'd4;
`endif

  initial begin
    int wraps;
    int prev;
    int guard;
    logic [3:0] ed;
    logic [3:0] em;

    for (int i = 0; i < 12; i++) begin
`ifdef COUNTER_RST_SYNC_EN
      ed = (i < 2) ? 4'd0 : (i < 8) ? 4'(i - 1) : 4'd0;
      em = (i < 2) ? 4'd0 : (i < 8) ? 4'(((i - 1) * 3) % 10) : 4'd0;
`else
      ed = (i < 8) ? 4'(i + 1) : (i < 10) ? 4'd0 : 4'(i - 9);
      em = (i < 8) ? 4'(((i + 1) * 3) % 10) : (i < 10) ? 4'd0 : 4'(((i - 9) * 3) % 10);
`endif
      vecs[i] = '{rst: (i == 8 || i == 9) ? 1'b0 : 1'b1, exp_def: ed, exp_m10: em};
    end

    // Asynchronous assertion without any clock edge.
    #1 set_reset(1'b0);
    #1;
    check("async_assert_def", int'(cnt_def), 0);
    check("async_assert_m10", int'(cnt_m10), 0);

    // Held in reset for 1000 ns.
    for (int i = 0; i < 100; i++) begin
      tick();
      check("hold_def", int'(cnt_def), 0);
      check("hold_m10", int'(cnt_m10), 0);
    end

    #2 set_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      if (reset != vecs[i].rst) set_reset(vecs[i].rst);
      tick();
      check($sformatf("vec%0d_def", i), int'(cnt_def), int'(vecs[i].exp_def));
      check($sformatf("vec%0d_m10", i), int'(cnt_m10), int'(vecs[i].exp_m10));
      check_model($sformatf("vec%0d_model", i));
      #2;
    end

    // 100 clocks from a fresh release: six wraps, ends at a fixed value.
    set_reset(1'b0);
    #1 check("mid_async_def", int'(cnt_def), 0);
    tick();
    #2 set_reset(1'b1);
    wraps = 0;
    prev = int'(cnt_def);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (int'(cnt_def) < prev) wraps++;
      prev = int'(cnt_def);
      check_model("run100");
    end
    check("run100_end", int'(cnt_def), int'(Exp100));
    check("run100_wraps", wraps, 6);

    // Reset dropped between edges while count is 9.
    guard = 0;
    while (cnt_def != 4'd9 && guard < 40) begin
      tick();
      guard++;
    end
    check("reach9_def", int'(cnt_def), 9);
    #2 set_reset(1'b0);
    #1;
    check("drop_at9_def", int'(cnt_def), 0);
    check("drop_at9_m10", int'(cnt_m10), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_model("drop_hold");
    end
    #2 set_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_model("resume");
    end

    // Toggle reset every 1000 ns for 5000 ns.
    for (int w = 0; w < 5; w++) begin
      #2 set_reset(w[0]);
      for (int i = 0; i < 100; i++) begin
        tick();
        check_model("toggle");
      end
      if (w[0]) check("toggle_end", int'(cnt_def), int'(Exp100));
      else check("toggle_low", int'(cnt_def), 0);
    end

    // Randomized reset activity against the model.
    #2 set_reset(1'b1);
    for (int i = 0; i < 2000; i++) begin
      int r;
      tick();
      check_model("rand");
      r = int'($urandom_range(0, 39));
      #2;
      if (reset && r == 0) begin
        set_reset(1'b0);
        #1;
        check("rand_async_def", int'(cnt_def), 0);
        check("rand_async_m10", int'(cnt_m10), 0);
      end else if (!reset && r < 10) begin
        set_reset(1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
